// File: rtl/pipelined_barrel_shifter_if.sv
// pipelined_barrel_shifter_if: operand/result valid-ready bundle for the pipelined barrel shifter
interface pipelined_barrel_shifter_if #(
  parameter int WIDTH = 8,
  parameter int SHW = $clog2(WIDTH)
);
  logic in_valid;
  logic in_ready;
  logic [WIDTH-1:0] data_in;
  logic [SHW-1:0] shamt_in;
  logic [1:0] mode_in;
  logic out_valid;
  logic out_ready;
  logic [WIDTH-1:0] data_out;
  logic zero_out;
  modport master (
    output in_valid, data_in, shamt_in, mode_in, out_ready,
    input in_ready, out_valid, data_out, zero_out
  );
  modport slave (
    input in_valid, data_in, shamt_in, mode_in, out_ready,
    output in_ready, out_valid, data_out, zero_out
  );
endinterface

// File: rtl/pipelined_barrel_shifter.sv
// pipelined_barrel_shifter: LSL/LSR/ASR/ROR with one registered mux level per shift-amount bit
module pipelined_barrel_shifter #(
  parameter int WIDTH = 8,
  parameter int SHW = $clog2(WIDTH)
) (
  input logic clk,
  input logic rst_n,
  pipelined_barrel_shifter_if.slave b
);
  logic [WIDTH-1:0] d_q [SHW];
  logic [SHW-1:0] v_q;
  logic [1:0] m_q [SHW-1];
  logic [SHW-1:0] a_q [SHW-1];
  logic [WIDTH-1:0] si_d [SHW];
  logic [1:0] si_m [SHW];
  logic [SHW-1:0] si_a [SHW];
  logic [SHW-1:0] si_v;
  logic adv;
  // ASR fill uses x's MSB, which every earlier ASR stage has preserved as the original sign
  function automatic logic [WIDTH-1:0] shift_by(input logic [WIDTH-1:0] x, input logic [1:0] m, input int s);
    logic [WIDTH-1:0] fill;
    fill = ~({WIDTH{1'b1}} >> s) & {WIDTH{x[WIDTH-1]}};
    return m == 2'b00 ? x << s :
           m == 2'b01 ? x >> s :
           m == 2'b10 ? (x >> s) | fill :
                        (x >> s) | (x << (WIDTH - s));
  endfunction
  assign adv = !v_q[SHW-1] | b.out_ready;
  assign b.in_ready = adv;
  assign b.out_valid = v_q[SHW-1];
  assign b.data_out = d_q[SHW-1];
  assign b.zero_out = v_q[SHW-1] & ~|d_q[SHW-1];
  always_comb begin
    si_d[0] = b.data_in;
    si_m[0] = b.mode_in;
    si_a[0] = b.shamt_in;
    si_v[0] = b.in_valid;
    for (int k = 1; k < SHW; k++) begin
      si_d[k] = d_q[k-1];
      si_m[k] = m_q[k-1];
      si_a[k] = a_q[k-1];
      si_v[k] = v_q[k-1];
    end
  end
  // amount travels right-shifted so each stage only ever tests bit 0
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      d_q <= '{default: '0};
      v_q <= '0;
      m_q <= '{default: '0};
      a_q <= '{default: '0};
    end else if (adv) begin
      v_q <= si_v;
      for (int k = 0; k < SHW; k++)
        d_q[k] <= si_a[k][0] ? shift_by(si_d[k], si_m[k], 1 << k) : si_d[k];
      for (int k = 0; k < SHW - 1; k++) begin
        m_q[k] <= si_m[k];
        a_q[k] <= si_a[k] >> 1;
      end
    end
endmodule
